// File: rtl/scene_config_regs.sv
// Command-addressed configuration register file with shadow/active banks.
// UART flash writes land in shadow; active follows immediately or at frame end.

module scene_cfg_slot #(
    parameter int                    DATA_WIDTH  = 96,
    parameter int                    COMMIT_MODE = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL    = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  frame_end,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] active,
    output logic                  dirty
);
    logic [DATA_WIDTH-1:0] r_active;
    logic                  r_dirty;

    // A write coincident with frame end still leaves the bit clear: it is committed by this frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_dirty <= 1'b0;
        else if (frame_end) r_dirty <= 1'b0;
        else if (we)        r_dirty <= 1'b1;
    end

    generate
        if (COMMIT_MODE == 0) begin : g_immediate
            // Shadow and active are always equal here, so one register serves both.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)     r_active <= INIT_VAL;
                else if (we) r_active <= data;
            end
        end else begin : g_deferred
            logic [DATA_WIDTH-1:0] r_shadow;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_shadow <= INIT_VAL;
                    r_active <= INIT_VAL;
                end else begin
                    if (we) r_shadow <= data;
                    if (frame_end) begin
                        if (we)           r_active <= data;
                        else if (r_dirty) r_active <= r_shadow;
                    end
                end
            end
        end
    endgenerate

    assign active = r_active;
    assign dirty  = r_dirty;
endmodule

module scene_config_regs #(
    parameter int                               NUM_REGS    = 8,
    parameter int                               DATA_WIDTH  = 96,
    parameter int                               CMD_WIDTH   = 8,
    parameter logic [CMD_WIDTH-1:0]             CMD_BASE    = '0,
    parameter int                               COMMIT_MODE = 1,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0]   INIT_VALS   = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flash_wen,
    input  logic [CMD_WIDTH-1:0]           flash_cmd,
    input  logic [DATA_WIDTH-1:0]          flash_data,
    input  logic                           frame_end,
    input  logic                           force_overwrite,
    output logic [NUM_REGS*DATA_WIDTH-1:0] cfg_regs,
    output logic [NUM_REGS-1:0]            cfg_dirty,
    output logic                           cmd_hit,
    output logic                           overwrite,
    output logic                           commit,
    output logic [7:0]                     frames_stable
);
    typedef struct packed {
        logic                  hit;
        logic [CMD_WIDTH-1:0]  idx;
        logic [DATA_WIDTH-1:0] data;
    } wr_req_t;

    wr_req_t               w_req;
    logic [NUM_REGS-1:0]   w_we;
    logic [NUM_REGS-1:0]   w_dirty;
    logic                  w_any;

    logic                  r_cmd_hit;
    logic                  r_overwrite;
    logic                  r_commit;
    logic [7:0]            r_frames_stable;

    // Codes above CMD_BASE+NUM_REGS (including ones past 2^CMD_WIDTH) never hit.
    always_comb begin
        w_req.idx  = flash_cmd - CMD_BASE;
        w_req.data = flash_data;
        w_req.hit  = flash_wen && (flash_cmd >= CMD_BASE) &&
                     (33'(w_req.idx) < 33'(NUM_REGS));
    end

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_slot
            assign w_we[i] = w_req.hit && (33'(w_req.idx) == 33'(i));
            scene_cfg_slot #(
                .DATA_WIDTH (DATA_WIDTH),
                .COMMIT_MODE(COMMIT_MODE),
                .INIT_VAL   (INIT_VALS[i*DATA_WIDTH +: DATA_WIDTH])
            ) u_slot (
                .clk      (clk),
                .rst      (rst),
                .we       (w_we[i]),
                .frame_end(frame_end),
                .data     (w_req.data),
                .active   (cfg_regs[i*DATA_WIDTH +: DATA_WIDTH]),
                .dirty    (w_dirty[i])
            );
        end
    endgenerate

    assign w_any = (|w_dirty) | w_req.hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd_hit       <= 1'b0;
            r_overwrite     <= 1'b1;
            r_commit        <= 1'b0;
            r_frames_stable <= 8'd0;
        end else begin
            r_cmd_hit <= w_req.hit;
            r_commit  <= frame_end & w_any;
            if (frame_end) begin
                r_overwrite <= force_overwrite | w_any;
                if (w_any)                         r_frames_stable <= 8'd0;
                else if (r_frames_stable != 8'hFF) r_frames_stable <= r_frames_stable + 8'd1;
            end
        end
    end

    assign cfg_dirty     = w_dirty;
    assign cmd_hit       = r_cmd_hit;
    assign overwrite     = r_overwrite;
    assign commit        = r_commit;
    assign frames_stable = r_frames_stable;
endmodule

// File: tb/tb_scene_config_regs.sv
// Directed bench: a deferred-commit instance (reg0 resets to 1) and an
// immediate-commit instance share the same stimulus.

module tb_scene_config_regs;
    localparam int NR = 8;
    localparam int DW = 96;
    localparam logic [NR*DW-1:0] INIT1 = {{(NR*DW-1){1'b0}}, 1'b1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wen = 1'b0;
    logic [7:0] cmd = '0;
    logic [DW-1:0] dat = '0;
    logic fe = 1'b0;
    logic fo = 1'b0;

    logic [NR*DW-1:0] cfg1, cfg0;
    logic [NR-1:0] dirty1, dirty0;
    logic hit1, hit0, ow1, ow0, cm1, cm0;
    logic [7:0] fs1, fs0;

    logic [NR*DW-1:0] e1, e0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scene_config_regs #(.NUM_REGS(NR), .DATA_WIDTH(DW), .CMD_WIDTH(8), .CMD_BASE(8'h00),
                        .COMMIT_MODE(1), .INIT_VALS(INIT1)) u_dut1 (
        .clk(clk), .rst(rst), .flash_wen(wen), .flash_cmd(cmd), .flash_data(dat),
        .frame_end(fe), .force_overwrite(fo), .cfg_regs(cfg1), .cfg_dirty(dirty1),
        .cmd_hit(hit1), .overwrite(ow1), .commit(cm1), .frames_stable(fs1));

    scene_config_regs #(.NUM_REGS(NR), .DATA_WIDTH(DW), .CMD_WIDTH(8), .CMD_BASE(8'h00),
                        .COMMIT_MODE(0)) u_dut0 (
        .clk(clk), .rst(rst), .flash_wen(wen), .flash_cmd(cmd), .flash_data(dat),
        .frame_end(fe), .force_overwrite(fo), .cfg_regs(cfg0), .cfg_dirty(dirty0),
        .cmd_hit(hit0), .overwrite(ow0), .commit(cm0), .frames_stable(fs0));

    // Drive one cycle of stimulus, then sample 1 time unit after the edge.
    task automatic cyc(input logic w, input logic [7:0] c, input logic [DW-1:0] d, input logic f);
        wen = w; cmd = c; dat = d; fe = f;
        @(posedge clk); #1;
        wen = 1'b0; fe = 1'b0;
    endtask

    task automatic test_reset;
        e1 = INIT1; e0 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cyc(1'b1, 8'h00, 96'hDEAD, 1'b0);
        cyc(1'b0, 8'h00, '0, 1'b1);
        cyc(1'b0, 8'h00, '0, 1'b1);
        cyc(1'b1, 8'h05, 96'h5, 1'b0);
        if (ow1 !== 1'b0) begin errors++; $display("FAIL pre_reset_ow: got %b want 0", ow1); end
        checks++;
        #2 rst = 1'b1;
        #1;
        if (cfg1 !== e1) begin errors++; $display("FAIL reset_cfg1: got %0h want %0h", cfg1, e1); end
        checks++;
        if (cfg0 !== e0) begin errors++; $display("FAIL reset_cfg0: got %0h want %0h", cfg0, e0); end
        checks++;
        if ({ow1, ow0} !== 2'b11) begin errors++; $display("FAIL reset_ow: got %b want 11", {ow1, ow0}); end
        checks++;
        if ({dirty1, dirty0} !== 16'h0) begin errors++; $display("FAIL reset_dirty: got %h want 0000", {dirty1, dirty0}); end
        checks++;
        if ({hit1, cm1, fs1, hit0, cm0, fs0} !== 20'h0) begin
            errors++; $display("FAIL reset_misc: got %h want 0", {hit1, cm1, fs1, hit0, cm0, fs0}); end
        checks++;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_deferred;
        cyc(1'b1, 8'h02, 96'hABC, 1'b0);
        e0[2*DW +: DW] = 96'hABC;
        if (dirty1 !== 8'b0000_0100) begin errors++; $display("FAIL def_dirty: got %b want 00000100", dirty1); end
        checks++;
        if (cfg1 !== e1) begin errors++; $display("FAIL def_hold: got %0h want %0h", cfg1, e1); end
        checks++;
        if (hit1 !== 1'b1) begin errors++; $display("FAIL def_hit: got %b want 1", hit1); end
        checks++;
        if (cfg0 !== e0) begin errors++; $display("FAIL imm_shadow: got %0h want %0h", cfg0, e0); end
        checks++;
        cyc(1'b0, 8'h00, '0, 1'b1);
        e1[2*DW +: DW] = 96'hABC;
        if (cfg1 !== e1) begin errors++; $display("FAIL def_commit_cfg: got %0h want %0h", cfg1, e1); end
        checks++;
        if ({cm1, ow1, fs1, dirty1, hit1} !== {1'b1, 1'b1, 8'd0, 8'd0, 1'b0}) begin
            errors++; $display("FAIL def_commit_flags: got %h want %h", {cm1, ow1, fs1, dirty1, hit1}, {1'b1, 1'b1, 8'd0, 8'd0, 1'b0}); end
        checks++;
        cyc(1'b0, 8'h00, '0, 1'b0);
        if (cm1 !== 1'b0) begin errors++; $display("FAIL commit_pulse: got %b want 0", cm1); end
        checks++;
    endtask

    task automatic test_out_of_range;
        cyc(1'b1, 8'h09, 96'hFFFF, 1'b0);
        if ({hit1, hit0, dirty1, dirty0} !== 18'h0) begin
            errors++; $display("FAIL oor9_flags: got %h want 0", {hit1, hit0, dirty1, dirty0}); end
        checks++;
        cyc(1'b1, 8'h08, 96'hFFFF, 1'b0);
        if ({hit1, dirty1} !== 9'h0) begin errors++; $display("FAIL oor8_flags: got %h want 0", {hit1, dirty1}); end
        checks++;
        if (cfg0 !== e0) begin errors++; $display("FAIL oor_cfg0: got %0h want %0h", cfg0, e0); end
        checks++;
        cyc(1'b1, 8'h07, 96'h77, 1'b0);
        e0[7*DW +: DW] = 96'h77;
        if ({hit1, dirty1} !== {1'b1, 8'h80}) begin errors++; $display("FAIL top_idx: got %h want 180", {hit1, dirty1}); end
        checks++;
        if (cfg1 !== e1) begin errors++; $display("FAIL top_idx_hold: got %0h want %0h", cfg1, e1); end
        checks++;
    endtask

    task automatic test_coincident;
        cyc(1'b1, 8'h01, 96'h55, 1'b1);
        e1[1*DW +: DW] = 96'h55; e1[7*DW +: DW] = 96'h77; e0[1*DW +: DW] = 96'h55;
        if (cfg1 !== e1) begin errors++; $display("FAIL coin_cfg1: got %0h want %0h", cfg1, e1); end
        checks++;
        if (cfg0 !== e0) begin errors++; $display("FAIL coin_cfg0: got %0h want %0h", cfg0, e0); end
        checks++;
        if ({dirty1, dirty0, cm1, cm0} !== {16'h0, 2'b11}) begin
            errors++; $display("FAIL coin_flags: got %h want 3", {dirty1, dirty0, cm1, cm0}); end
        checks++;
    endtask

    task automatic test_back_to_back;
        cyc(1'b1, 8'h04, 96'h44, 1'b0);
        e0[4*DW +: DW] = 96'h44;
        cyc(1'b0, 8'h00, '0, 1'b1);
        e1[4*DW +: DW] = 96'h44;
        fe = 1'b1;
        if ({cm1, fs1, ow1} !== {1'b1, 8'd0, 1'b1}) begin
            errors++; $display("FAIL b2b_first: got %h want %h", {cm1, fs1, ow1}, {1'b1, 8'd0, 1'b1}); end
        checks++;
        if (cfg1 !== e1) begin errors++; $display("FAIL b2b_cfg: got %0h want %0h", cfg1, e1); end
        checks++;
        @(posedge clk); #1 fe = 1'b0;
        if ({cm1, fs1, ow1, cm0, fs0, ow0} !== {1'b0, 8'd1, 1'b0, 1'b0, 8'd1, 1'b0}) begin
            errors++; $display("FAIL b2b_second: got %h want %h", {cm1, fs1, ow1, cm0, fs0, ow0}, {1'b0, 8'd1, 1'b0, 1'b0, 8'd1, 1'b0}); end
        checks++;
    endtask

    task automatic test_stability;
        fe = 1'b1;
        repeat (253) @(posedge clk);
        #1;
        if (fs1 !== 8'd254) begin errors++; $display("FAIL stab_254: got %0d want 254", fs1); end
        checks++;
        repeat (47) @(posedge clk);
        #1 fe = 1'b0;
        if ({ow1, cm1, fs1, ow0, fs0} !== {1'b0, 1'b0, 8'd255, 1'b0, 8'd255}) begin
            errors++; $display("FAIL stab_sat: got %h want %h", {ow1, cm1, fs1, ow0, fs0}, {1'b0, 1'b0, 8'd255, 1'b0, 8'd255}); end
        checks++;
        fo = 1'b1;
        cyc(1'b0, 8'h00, '0, 1'b1);
        fo = 1'b0;
        if ({ow1, cm1, fs1} !== {1'b1, 1'b0, 8'd255}) begin
            errors++; $display("FAIL force_ow: got %h want %h", {ow1, cm1, fs1}, {1'b1, 1'b0, 8'd255}); end
        checks++;
        if (cfg1 !== e1) begin errors++; $display("FAIL stab_cfg: got %0h want %0h", cfg1, e1); end
        checks++;
    endtask

    task automatic test_immediate;
        cyc(1'b1, 8'h03, 96'h7, 1'b0);
        e0[3*DW +: DW] = 96'h7;
        if (cfg0 !== e0) begin errors++; $display("FAIL imm_cfg: got %0h want %0h", cfg0, e0); end
        checks++;
        if (dirty0 !== 8'b0000_1000) begin errors++; $display("FAIL imm_dirty: got %b want 00001000", dirty0); end
        checks++;
        if (cfg1 !== e1) begin errors++; $display("FAIL imm_def_hold: got %0h want %0h", cfg1, e1); end
        checks++;
        cyc(1'b0, 8'h00, '0, 1'b1);
        e1[3*DW +: DW] = 96'h7;
        if ({ow0, dirty0, cm0, fs0} !== {1'b1, 8'h0, 1'b1, 8'd0}) begin
            errors++; $display("FAIL imm_fe: got %h want %h", {ow0, dirty0, cm0, fs0}, {1'b1, 8'h0, 1'b1, 8'd0}); end
        checks++;
        if (cfg1 !== e1) begin errors++; $display("FAIL imm_def_commit: got %0h want %0h", cfg1, e1); end
        checks++;
    endtask

    initial begin
        test_reset();
        test_deferred();
        test_out_of_range();
        test_coincident();
        test_back_to_back();
        test_stability();
        test_immediate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
